// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed synchronous data memory.
// Handles sub-word read-modify-write, load extension and access error detection.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqUnsigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespData,
    output logic        RespError,
    output logic [31:0] MemAddress,
    output logic        MemWriteEnable,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        write_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        req_err;

    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]         b;
        logic signed [7:0]  b_s;
        logic [15:0]        h;
        logic signed [15:0] h_s;
        logic [31:0]        r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h   = lane[1] ? word[31:16] : word[15:0];
        b_s = $signed(b);
        h_s = $signed(h);
        case (size)
            2'b00:   r = uns ? {24'd0, b} : 32'(b_s);
            2'b01:   r = uns ? {16'd0, h} : 32'(h_s);
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane(s) of the word just read back.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old_word,
        input logic [31:0] new_data,
        input logic [1:0]  lane,
        input logic [1:0]  size
    );
        logic [31:0] w;
        w = old_word;
        if (size == 2'b00) begin
            case (lane)
                2'd0:    w[7:0]   = new_data[7:0];
                2'd1:    w[15:8]  = new_data[7:0];
                2'd2:    w[23:16] = new_data[7:0];
                default: w[31:24] = new_data[7:0];
            endcase
        end else if (size == 2'b01) begin
            if (lane[1]) w[31:16] = new_data[15:0];
            else         w[15:0]  = new_data[15:0];
        end else begin
            w = new_data;
        end
        return w;
    endfunction

    always_comb begin
        req_err = (ReqSize == 2'b11)
               || ((ReqSize == 2'b01) && ReqAddr[0])
               || ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00))
               || ({2'b00, ReqAddr[31:2]} >= WORD_LIMIT);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        ReqReady       = 1'b0;
        RespValid      = 1'b0;
        MemWriteEnable = 1'b0;
        MemWriteData   = 32'd0;
        MemAddress     = 32'd0;
        case (state)
            IDLE: begin
                ReqReady = !Reset;
                if (ReqValid) begin
                    if (req_err)                             state_next = RESP;
                    else if (ReqWrite && (ReqSize == 2'b10)) state_next = WR;
                    else                                     state_next = RD;
                end
            end
            RD: begin
                MemAddress = {2'b00, addr_q[31:2]};
                state_next = MERGE;
            end
            MERGE: begin
                MemAddress = {2'b00, addr_q[31:2]};
                state_next = write_q ? WR : RESP;
            end
            WR: begin
                MemAddress     = {2'b00, addr_q[31:2]};
                MemWriteEnable = 1'b1;
                MemWriteData   = wdata_q;
                state_next     = RESP;
            end
            RESP: begin
                RespValid = 1'b1;
                if (RespReady) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            write_q   <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        write_q   <= ReqWrite;
                        size_q    <= ReqSize;
                        uns_q     <= ReqUnsigned;
                        addr_q    <= ReqAddr;
                        wdata_q   <= ReqWData;
                        resp_data <= 32'd0;
                        resp_err  <= req_err;
                    end
                end
                // Read data arrives here, one cycle after the RD address.
                MERGE: begin
                    if (write_q) wdata_q   <= merge_store(MemReadData, wdata_q, addr_q[1:0], size_q);
                    else         resp_data <= extend_load(MemReadData, addr_q[1:0], size_q, uns_q);
                end
                RESP: begin
                    if (RespReady) begin
                        resp_data <= 32'd0;
                        resp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RespData  = resp_data;
    assign RespError = resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous word memory.
module tb_load_store_unit;

    logic        Clock;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespData;
    logic        RespError;
    logic [31:0] MemAddress;
    logic        MemWriteEnable;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .ReqAddr(ReqAddr),
        .ReqWData(ReqWData), .RespValid(RespValid), .RespReady(RespReady),
        .RespData(RespData), .RespError(RespError), .MemAddress(MemAddress),
        .MemWriteEnable(MemWriteEnable), .MemWriteData(MemWriteData),
        .MemReadData(MemReadData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory model, with a preload port so only this process writes the array.
    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;
    int          we_count;

    initial begin
        pl_en       = 1'b0;
        pl_addr     = 10'd0;
        pl_data     = 32'd0;
        MemReadData = 32'd0;
        we_count    = 0;
    end

    always @(posedge Clock) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (MemWriteEnable) begin
            if (MemAddress < 32'd1024) mem[MemAddress[9:0]] <= MemWriteData;
            we_count <= we_count + 1;
        end else begin
            MemReadData <= (MemAddress < 32'd1024) ? mem[MemAddress[9:0]] : 32'd0;
        end
    end

    int          tests_run;
    int          tests_failed;
    int          lat;
    logic [31:0] rdata;
    logic        rerr;
    logic        we_seen;
    logic [31:0] we_data;
    logic [31:0] we_addr;
    int          we0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge Clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge Clock);
        #1 pl_en = 1'b0;
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
        int i;
        @(negedge Clock);
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqUnsigned = u;
        ReqAddr = a; ReqWData = d;
        i = 0;
        while (!ReqReady && i < 20) begin
            @(negedge Clock);
            i++;
        end
        if (!ReqReady) check("accept", 32'(ReqReady), 32'd1);
        @(posedge Clock);
        #1 ReqValid = 1'b0;
    endtask

    // Cycle n=1 is the cycle right after the accept edge.
    task automatic collect(input bit hs);
        lat = 99; rdata = 32'd0; rerr = 1'b0;
        we_seen = 1'b0; we_data = 32'd0; we_addr = 32'd0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clock);
            if (MemWriteEnable) begin
                we_seen = 1'b1; we_data = MemWriteData; we_addr = MemAddress;
            end
            if (RespValid) begin
                lat = n; rdata = RespData; rerr = RespError;
                break;
            end
        end
        if (hs && lat != 99) begin
            RespReady = 1'b1;
            @(posedge Clock);
            #1 RespReady = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0; tests_failed = 0;
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
        ReqUnsigned = 1'b0; ReqAddr = 32'd0; ReqWData = 32'd0; RespReady = 1'b0;

        repeat (3) @(negedge Clock);
        check("rst_ready",  32'(ReqReady), 32'd0);
        check("rst_rvalid", 32'(RespValid), 32'd0);
        check("rst_we",     32'(MemWriteEnable), 32'd0);
        check("rst_maddr",  MemAddress, 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        check("idle_ready", 32'(ReqReady), 32'd1);

        preload(10'd5, 32'h0000_0000);
        preload(10'd6, 32'h1122_3344);
        preload(10'd1023, 32'hA5A5_0001);

        // Word store then word load
        send(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEAD_BEEF); collect(1'b1);
        check("sw_lat",   32'(lat), 32'd2);
        check("sw_wdata", we_data, 32'hDEAD_BEEF);
        check("sw_waddr", we_addr, 32'd5);
        check("sw_err",   32'(rerr), 32'd0);
        check("sw_rdata", rdata, 32'd0);
        check("sw_mem",   mem[5], 32'hDEAD_BEEF);
        send(1'b0, 2'b10, 1'b0, 32'h14, 32'd0); collect(1'b1);
        check("lw_lat",  32'(lat), 32'd3);
        check("lw_data", rdata, 32'hDEAD_BEEF);
        check("lw_err",  32'(rerr), 32'd0);
        check("lw_nowe", 32'(we_seen), 32'd0);

        // Byte RMW and byte loads
        send(1'b1, 2'b00, 1'b0, 32'h16, 32'hAAAA_AA55); collect(1'b1);
        check("sb_lat",   32'(lat), 32'd4);
        check("sb_wdata", we_data, 32'hDE55_BEEF);
        check("sb_waddr", we_addr, 32'd5);
        send(1'b0, 2'b00, 1'b0, 32'h17, 32'd0); collect(1'b1);
        check("lb_s",     rdata, 32'hFFFF_FFDE);
        check("lb_s_lat", 32'(lat), 32'd3);
        send(1'b0, 2'b00, 1'b1, 32'h17, 32'd0); collect(1'b1);
        check("lb_u", rdata, 32'h0000_00DE);
        send(1'b0, 2'b00, 1'b1, 32'h15, 32'd0); collect(1'b1);
        check("lb_u1", rdata, 32'h0000_00BE);

        // Halfword RMW and halfword loads
        send(1'b1, 2'b01, 1'b0, 32'h16, 32'hCCCC_1234); collect(1'b1);
        check("sh_lat",   32'(lat), 32'd4);
        check("sh_wdata", we_data, 32'h1234_BEEF);
        send(1'b0, 2'b01, 1'b0, 32'h14, 32'd0); collect(1'b1);
        check("lh_s", rdata, 32'hFFFF_BEEF);
        send(1'b0, 2'b01, 1'b1, 32'h14, 32'd0); collect(1'b1);
        check("lh_u", rdata, 32'h0000_BEEF);

        // Last valid word
        send(1'b0, 2'b10, 1'b0, 32'hFFC, 32'd0); collect(1'b1);
        check("top_err",  32'(rerr), 32'd0);
        check("top_data", rdata, 32'hA5A5_0001);

        // Error cases
        send(1'b0, 2'b10, 1'b0, 32'h13, 32'd0); collect(1'b1);
        check("e_mis_lat",  32'(lat), 32'd1);
        check("e_mis_err",  32'(rerr), 32'd1);
        check("e_mis_data", rdata, 32'd0);
        we0 = we_count;
        send(1'b1, 2'b01, 1'b0, 32'h15, 32'h0000_7777); collect(1'b1);
        check("e_sh_err", 32'(rerr), 32'd1);
        check("e_sh_we",  32'(we_seen), 32'd0);
        check("e_sh_cnt", 32'(we_count - we0), 32'd0);
        send(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0); collect(1'b1);
        check("e_oor_err", 32'(rerr), 32'd1);
        check("e_oor_lat", 32'(lat), 32'd1);
        send(1'b0, 2'b11, 1'b0, 32'h14, 32'd0); collect(1'b1);
        check("e_sz_err",  32'(rerr), 32'd1);
        check("e_sz_data", rdata, 32'd0);

        // Response backpressure with a competing request held
        send(1'b0, 2'b10, 1'b0, 32'h14, 32'd0); collect(1'b0);
        check("bp_lat",  32'(lat), 32'd3);
        check("bp_data", rdata, 32'h1234_BEEF);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b01; ReqUnsigned = 1'b1;
        ReqAddr = 32'h16; ReqWData = 32'd0;
        repeat (5) begin
            @(negedge Clock);
            check("bp_valid", 32'(RespValid), 32'd1);
            check("bp_hold",  RespData, 32'h1234_BEEF);
            check("bp_ready", 32'(ReqReady), 32'd0);
        end
        RespReady = 1'b1;
        @(posedge Clock);
        #1 RespReady = 1'b0;
        @(negedge Clock);
        check("bp_idle",  32'(RespValid), 32'd0);
        check("bp_rdy",   32'(ReqReady), 32'd1);
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        collect(1'b1);
        check("bp2_lat",  32'(lat), 32'd3);
        check("bp2_data", rdata, 32'h0000_1234);

        // Reset during the MERGE cycle of a byte store
        we0 = we_count;
        send(1'b1, 2'b00, 1'b0, 32'h18, 32'hAAAA_AA99);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("mr_ready", 32'(ReqReady), 32'd0);
        check("mr_we",    32'(MemWriteEnable), 32'd0);
        check("mr_maddr", MemAddress, 32'd0);
        check("mr_wdata", MemWriteData, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (4) @(negedge Clock);
        check("mr_cnt",    32'(we_count - we0), 32'd0);
        check("mr_mem",    mem[6], 32'h1122_3344);
        check("mr_idle",   32'(ReqReady), 32'd1);
        check("mr_rvalid", 32'(RespValid), 32'd0);
        check("mr_rdata",  RespData, 32'd0);
        check("mr_rerr",   32'(RespError), 32'd0);
        check("mr_maddr2", MemAddress, 32'd0);
        send(1'b0, 2'b10, 1'b0, 32'h18, 32'd0); collect(1'b1);
        check("mr_load", rdata, 32'h1122_3344);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory (32-bit words; synchronous read registered at posedge when write-enable is low; write at posedge when write-enable is high).
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Performs byte/halfword read-modify-write and load extension, flags misaligned or out-of-range accesses, and returns results over a valid/ready response channel.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the data memory; word indices at or above this are out of range.

Ports:
- Clock  input  1  single clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- ReqValid  input  1  request present
- ReqReady  output  1  unit can accept a request
- ReqWrite  input  1  1=store, 0=load
- ReqSize  input  2  00=byte, 01=half, 10=word, 11=illegal
- ReqUnsigned  input  1  loads only: 1=zero-extend, 0=sign-extend
- ReqAddr  input  32  byte address
- ReqWData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- RespValid  output  1  response present
- RespReady  input  1  consumer accepts response
- RespData  output  32  load result (0 for stores and errors)
- RespError  output  1  misaligned, out-of-range or illegal size
- MemAddress  output  32  word index {2'b00, addr[31:2]}
- MemWriteEnable  output  1  write strobe to memory
- MemWriteData  output  32  full word to write
- MemReadData  input  32  memory read data (valid the cycle after address presented with write-enable low)

Behaviour:
- States: IDLE, RD, MERGE, WR, RESP.
- ReqReady = 1 only in IDLE and not in reset. RespValid = 1 only in RESP. MemWriteEnable = 1 only in WR.
- Accept: at an edge with ReqValid && ReqReady, latch write, size, unsigned, addr and wdata.
- Error check at accept. Any of the following raises an error:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=00
  - addr[31:2] >= MEM_WORDS
- On error: go to RESP with RespError=1, RespData=0. No memory write occurs.
- Word store: IDLE -> WR -> RESP. MemWriteData = wdata.
- Load: IDLE -> RD -> MERGE -> RESP.
  - RD drives MemAddress with write-enable low.
  - MERGE samples MemReadData and registers the extended result into RespData.
- Sub-word store: IDLE -> RD -> MERGE -> WR -> RESP.
  - MERGE builds the merged word in a register and replaces only the addressed lane(s).
  - Little-endian lanes: byte n = bits [8n+7:8n]; half at addr[1]=1 uses bits [31:16].
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign- or zero-extend per ReqUnsigned.
  - Word returns the read data unchanged.
- Latency (accept edge = k): RESP is first visible in cycle k+2 (word store), k+3 (load), k+4 (sub-word store), k+1 (error).
- RESP holds RespData/RespError stable until RespReady=1; at that edge the FSM returns to IDLE.
- No new request is accepted in the same cycle as the response handshake; the next accept is possible one cycle later.
- MemAddress holds the latched word index from RD through WR. In IDLE it is 0.
- Reset (any time, including mid-RMW):
  - Asynchronously go to IDLE.
  - RespValid=0, RespData=0, RespError=0, MemWriteEnable=0, MemWriteData=0, MemAddress=0, ReqReady=0 while Reset is high.
  - A pending store is abandoned and memory is left unmodified.
- Requests presented while not ready are ignored; the requester must hold them.

Test Plan:
- Word store then load: mem[5]=0. Store word 0xDEADBEEF at addr 0x14 -> WR cycle writes 0xDEADBEEF to MemAddress 5, RESP at k+2. Load word 0x14 -> RespData=0xDEADBEEF, RespError=0, RESP at k+3.
- Byte RMW: mem[5]=0xDEADBEEF. Store byte 0x55 at 0x16 -> MemWriteData=0xDE55BEEF. Load byte signed 0x17 -> 0xFFFFFFDE. Load byte unsigned 0x17 -> 0x000000DE.
- Halfword: mem[5]=0xDE55BEEF. Store half 0x1234 at 0x16 -> 0x1234BEEF. Load half signed 0x14 -> 0xFFFFBEEF. Load half unsigned -> 0x0000BEEF.
- Errors:
  - Load word at 0x13 -> RespError=1, RespData=0 at k+1.
  - Store half at 0x15 -> error, MemWriteEnable never asserts.
  - Addr 0x1000 (word 1024) -> error.
  - Size 11 -> error.
- Backpressure: hold RespReady=0 for 5 cycles after a load -> RespValid and RespData stable. ReqReady=0 throughout, and a new ReqValid is not accepted until one cycle after the RespReady handshake.
- Reset mid-RMW: assert Reset during the MERGE cycle of a byte store -> MemWriteEnable never asserts, memory word unchanged. After release, state is IDLE, ReqReady=1, all outputs 0.
